// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/exec/mem/wb
// over a shared ALU and a single memory port, with a bus-timeout trap.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic [1:0]       result_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic             alu_force_add,
  output logic             alu_out_we,
  output logic [2:0]       state,
  output logic             trap,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit          TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : TO_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              trap_q, trap_d;
  logic              bus_err_q, bus_err_d;

  logic [6:0] opcode;
  logic       is_store, is_load, is_jal, is_jalr, legal;
  logic       timeout_hit;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign unused_inst = ^inst[31:7];
  assign is_store    = (opcode == OP_STORE);
  assign is_load     = (opcode == OP_LOAD);
  assign is_jal      = (opcode == OP_JAL);
  assign is_jalr     = (opcode == OP_JALR);
  assign legal       = (opcode == OP_R) || (opcode == OP_IMM) || is_load || is_store ||
                       (opcode == OP_BRANCH) || is_jal || is_jalr ||
                       (opcode == OP_LUI) || (opcode == OP_AUIPC);
  // Last permitted waiting cycle of a memory access, when timeouts are enabled.
  assign timeout_hit = TO_EN && (wait_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    bus_err_d     = bus_err_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 1'b0;
    reg_we        = 1'b0;
    result_sel    = 2'd0;
    alu_a_sel     = 2'd0;
    alu_b_sel     = 1'b0;
    alu_force_add = 1'b0;
    alu_out_we    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        // Latch PC+imm as the branch/jal target.
        alu_a_sel     = 2'd1;
        alu_b_sel     = 1'b1;
        alu_force_add = 1'b1;
        alu_out_we    = 1'b1;
        if (!legal)      state_d = S_TRAP;
        else if (is_jal) state_d = S_WB;
        else             state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_out_we = 1'b1;
            state_d    = S_WB;
          end
          OP_IMM: begin
            alu_b_sel  = 1'b1;
            alu_out_we = 1'b1;
            state_d    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            alu_out_we    = 1'b1;
            state_d       = S_MEM;
          end
          OP_JALR: begin
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            alu_out_we    = 1'b1;
            state_d       = S_WB;
          end
          OP_LUI: begin
            alu_a_sel     = 2'd2;
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            alu_out_we    = 1'b1;
            state_d       = S_WB;
          end
          OP_AUIPC: begin
            alu_a_sel     = 2'd1;
            alu_b_sel     = 1'b1;
            alu_force_add = 1'b1;
            alu_out_we    = 1'b1;
            state_d       = S_WB;
          end
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = branch_taken;
            state_d = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        pc_src     = is_jal || is_jalr;
        result_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        state_d    = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_d = '0;
    end

    // Reset silences every strobe in the cycle it is asserted.
    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      addr_sel      = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 1'b0;
      reg_we        = 1'b0;
      result_sel    = 2'd0;
      alu_a_sel     = 2'd0;
      alu_b_sel     = 1'b0;
      alu_force_add = 1'b0;
      alu_out_we    = 1'b0;
    end

    trap_d    = trap_q || (state_d == S_TRAP);
    instret_d = instret_q + CNT_W'(pc_we);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state   = state_q;
  assign trap    = trap_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model queues the
// expected per-cycle control vector; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we;
  logic [1:0]  result_sel, alu_a_sel;
  logic        alu_b_sel, alu_force_add, alu_out_we;
  logic [2:0]  state;
  logic        trap, bus_err;
  logic [31:0] instret;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .result_sel(result_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_force_add(alu_force_add),
    .alu_out_we(alu_out_we), .state(state), .trap(trap), .bus_err(bus_err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  state;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we;
    logic [1:0]  result_sel, alu_a_sel;
    logic        alu_b_sel, alu_force_add, alu_out_we, trap, bus_err;
    logic [31:0] instret;
  } exp_t;

  exp_t  exp_q[$];
  string lbl_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Architectural model state (not the DUT's encoding).
  logic [31:0] m_instret = 0;
  logic        m_trap = 1'b0;
  logic        m_bus  = 1'b0;

  typedef enum int {K_ILL, K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC} kind_t;

  function automatic kind_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.state   = st;
    e.trap    = m_trap;
    e.bus_err = m_bus;
    e.instret = m_instret;
    return e;
  endfunction

  // Present one cycle of inputs and queue what the controller must show in it.
  task automatic emit(input exp_t e, input logic rdy, input string lbl);
    mem_ready = rdy;
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
    @(posedge clk);
    #1;
    if (e.pc_we) m_instret = m_instret + 32'd1;
  endtask

  task automatic do_reset(input logic [2:0] cur_state);
    reset = 1'b1;
    emit(blank(cur_state), 1'($urandom), "reset");
    reset = 1'b0;
    m_instret = 0;
    m_trap = 1'b0;
    m_bus = 1'b0;
  endtask

  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++) begin
      branch_taken = 1'($urandom);
      emit(blank(3'd5), 1'($urandom), "trap_hold");
    end
    do_reset(3'd5);
  endtask

  // A memory access that completes after wait_n stalled cycles, times out, or is cut by reset.
  task automatic mem_phase(input logic [2:0] st, input int wait_n, input logic store,
                           input int abort_at, output bit ok);
    exp_t e;
    ok = 1'b0;
    for (int w = 0; w < 64; w++) begin
      if (w == abort_at) begin
        do_reset(st);
        return;
      end
      e = blank(st);
      e.mem_req  = 1'b1;
      e.addr_sel = (st == 3'd3);
      e.mem_we   = (st == 3'd3) && store;
      if (w == wait_n) begin
        if (st == 3'd0) e.ir_we = 1'b1;
        else if (store) e.pc_we = 1'b1;
        emit(e, 1'b1, (st == 3'd0) ? "fetch_done" : "mem_done");
        ok = 1'b1;
        return;
      end
      emit(e, 1'b0, (st == 3'd0) ? "fetch_wait" : "mem_wait");
      if (TO != 0 && w + 1 >= int'(TO)) begin
        m_trap = 1'b1;
        m_bus  = 1'b1;
        trap_tail(3);
        return;
      end
    end
  endtask

  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw,
                          input logic tk, input int abort_mem, input int trap_len);
    exp_t  e;
    bit    ok;
    kind_t k;
    inst = ins;
    branch_taken = tk;
    k = classify(ins[6:0]);
    mem_phase(3'd0, fw, 1'b0, -1, ok);
    if (!ok) return;

    e = blank(3'd1);
    e.alu_a_sel = 2'd1; e.alu_b_sel = 1'b1; e.alu_force_add = 1'b1; e.alu_out_we = 1'b1;
    emit(e, 1'($urandom), "decode");
    if (k == K_ILL) begin
      m_trap = 1'b1;
      trap_tail(trap_len);
      return;
    end

    if (k != K_JAL) begin
      e = blank(3'd2);
      e.alu_out_we = 1'b1;
      case (k)
        K_I:        e.alu_b_sel = 1'b1;
        K_LD, K_ST, K_JALR: begin e.alu_b_sel = 1'b1; e.alu_force_add = 1'b1; end
        K_LUI:   begin e.alu_a_sel = 2'd2; e.alu_b_sel = 1'b1; e.alu_force_add = 1'b1; end
        K_AUIPC: begin e.alu_a_sel = 2'd1; e.alu_b_sel = 1'b1; e.alu_force_add = 1'b1; end
        K_BR:    begin e.alu_out_we = 1'b0; e.pc_we = 1'b1; e.pc_src = tk; end
        default: ;
      endcase
      emit(e, 1'($urandom), "exec");
      if (k == K_BR) return;
      if (k == K_LD || k == K_ST) begin
        mem_phase(3'd3, mw, k == K_ST, abort_mem, ok);
        if (!ok || k == K_ST) return;
      end
    end

    e = blank(3'd4);
    e.reg_we = 1'b1;
    e.pc_we  = 1'b1;
    e.pc_src = (k == K_JAL) || (k == K_JALR);
    e.result_sel = (k == K_LD) ? 2'd1 : (((k == K_JAL) || (k == K_JALR)) ? 2'd2 : 2'd0);
    emit(e, 1'($urandom), "writeback");
  endtask

  always @(negedge clk) begin
    exp_t  e, a;
    string l;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      a = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we,
           result_sel, alu_a_sel, alu_b_sel, alu_force_add, alu_out_we,
           trap, bus_err, instret};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s @%0t: got %h required %h", l, $time, a, e);
      end
    end
  end

  localparam logic [6:0] LEGAL_OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [31:0] ri;
    int fw, mw;
    reset = 1'b1;
    inst = 32'h0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3'd0);

    do_instr(32'h00500093, 0, 0, 1'b0, -1, 3);   // addi x1,x0,5
    do_instr(32'h0000A103, 2, 2, 1'b0, -1, 3);   // lw, two stalls each side
    do_instr(32'h00208063, 0, 0, 1'b1, -1, 3);   // beq taken
    do_instr(32'h00208063, 0, 0, 1'b0, -1, 3);   // beq not taken
    do_instr(32'h0020A023, 0, 1, 1'b0, -1, 3);   // sw
    do_instr(32'h008000EF, 0, 0, 1'b0, -1, 3);   // jal
    do_instr(32'h000080E7, 1, 0, 1'b1, -1, 3);   // jalr
    do_instr(32'h123450B7, 0, 0, 1'b0, -1, 3);   // lui
    do_instr(32'h00001097, 0, 0, 1'b0, -1, 3);   // auipc
    do_instr(32'h0000007F, 0, 0, 1'b0, -1, 20);  // illegal opcode
    do_instr(32'h00500093, 3, 0, 1'b0, -1, 3);   // ready on the last allowed wait cycle
    do_instr(32'h00500093, 10, 0, 1'b0, -1, 3);  // fetch timeout
    do_instr(32'h0000A103, 0, 3, 1'b0, -1, 3);   // load, ready on last allowed MEM wait
    do_instr(32'h0020A023, 0, 10, 1'b0, -1, 3);  // store timeout in MEM
    do_instr(32'h0000A103, 0, 10, 1'b0, 2, 3);   // reset during MEM
    do_instr(32'h00500093, 0, 0, 1'b0, -1, 3);

    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 19) == 0) ri[6:0] = 7'($urandom);
      else ri[6:0] = LEGAL_OPS[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
      do_instr(ri, fw, mw, 1'($urandom), ($urandom_range(0, 39) == 0) ? 1 : -1, 3);
    end

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
